// File: rtl/mmu.sv
// mmu: shared types for the TLB refill path.
//   psize_t  - page size tag written into the TLB alongside each entry.
//   lvl_t    - page-table walk level (2 = 1GB table, 0 = 4KB table).
//   pte_t    - 32-bit PTE layout: [31:10] PPN, [9:8] RSW, [7:0] D A G U X W R V.
//   helpers  - PTE classification, misalignment test, PTE address formation.
`ifndef VLEN
`define VLEN 39
`endif
`ifndef PLEN
`define PLEN 34
`endif

package mmu;
  localparam int VLEN = `VLEN;
  localparam int PLEN = `PLEN;
  localparam int PPNW = PLEN - 12;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  typedef enum logic [1:0] {
    PSIZE_4KB = 2'd0,
    PSIZE_2MB = 2'd1,
    PSIZE_1GB = 2'd2
  } psize_t;

  typedef enum logic [1:0] {
    LVL0 = 2'd0,
    LVL1 = 2'd1,
    LVL2 = 2'd2
  } lvl_t;

  typedef struct packed {
    logic [PPNW-1:0] ppn;
    logic [1:0]      rsw;
    logic            d, a, g, u, x, w, r, v;
  } pte_t;

  function automatic logic pte_invalid(input logic [31:0] p);
    return !p[PTE_V] || (p[PTE_W] && !p[PTE_R]);
  endfunction

  function automatic logic pte_pointer(input logic [31:0] p);
    return p[PTE_V] && !p[PTE_R] && !p[PTE_W] && !p[PTE_X];
  endfunction

  // Superpage leaves must have the PPN bits they do not translate cleared.
  function automatic logic pte_misaligned(input logic [PPNW-1:0] ppn, input lvl_t l);
    return (l == LVL2 && ppn[17:0] != '0) || (l == LVL1 && ppn[8:0] != '0);
  endfunction

  function automatic psize_t lvl_psize(input lvl_t l);
    case (l)
      LVL2:    return PSIZE_1GB;
      LVL1:    return PSIZE_2MB;
      default: return PSIZE_4KB;
    endcase
  endfunction

  // Table base is page aligned, so base + idx*4 is a plain concatenation.
  function automatic logic [PLEN-1:0] pte_addr(input logic [PPNW-1:0] ppn,
                                               input logic [VLEN-13:0] vpn,
                                               input lvl_t l);
    logic [8:0] idx;
    case (l)
      LVL2:    idx = vpn[26:18];
      LVL1:    idx = vpn[17:9];
      default: idx = vpn[8:0];
    endcase
    return {ppn, 1'b0, idx, 2'b00};
  endfunction
endpackage

// File: rtl/page_table_walker.sv
// page_table_walker: TLB refill engine. On a miss it walks a 3-level table of
// 32-bit PTEs (1GB / 2MB / 4KB) over a single-outstanding read port, writes
// the leaf into the MMU TLB, and reports done/fault/abort to the requester.
// Ports:
//   clock, reset            - clock, synchronous active-high reset
//   walk_req/vaddr/root_ppn - walk start (sampled in IDLE)
//   walk_done/fault/abort   - one-cycle completion pulse with status
//   invalidate              - MMU invalidate; aborts any walk in flight
//   mem_req/addr/ack/rdata/err - PTE read port, request held until ack
//   entry/vpn_out/psize_out/pte_out/pte_write - TLB write port
// lp_tlb_log2count / np_tlb_log2ways size the victim counters (1..5 bits).
module page_table_walker
  import mmu::*;
#(
  parameter int lp_tlb_log2count = 3,
  parameter int np_tlb_log2ways  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              walk_req,
  input  logic [`VLEN-1:0]  walk_vaddr,
  input  logic [`PLEN-13:0] root_ppn,
  output logic              walk_done,
  output logic              walk_fault,
  output logic              walk_abort,
  input  logic              invalidate,
  output logic              mem_req,
  output logic [`PLEN-1:0]  mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err,
  output logic [4:0]        entry,
  output logic [`VLEN-13:0] vpn_out,
  output psize_t            psize_out,
  output logic [31:0]       pte_out,
  output logic              pte_write
);
  localparam int LPW = lp_tlb_log2count;
  localparam int NPW = np_tlb_log2ways;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CHECK, S_WRITE, S_DONE} state_t;

  state_t            r_state;
  lvl_t              r_lvl;
  logic [VLEN-13:0]  r_vpn;
  pte_t              r_pte;
  logic              r_err;
  logic              r_abort;
  logic [LPW-1:0]    r_lp_ctr;
  logic [NPW-1:0]    r_np_ctr;
  logic              r_walk_done, r_walk_fault, r_walk_abort;
  logic              r_mem_req;
  logic [PLEN-1:0]   r_mem_addr;
  logic [4:0]        r_entry;
  logic [VLEN-13:0]  r_vpn_out;
  psize_t            r_psize;
  logic [31:0]       r_pte_out;
  logic              r_pte_write;

  logic w_abort;
  lvl_t w_next_lvl;
  logic w_unused_vaddr;

  // An invalidate in this very cycle counts as well as one seen earlier.
  assign w_abort        = r_abort | invalidate;
  assign w_next_lvl     = lvl_t'(r_lvl - 2'd1);
  assign w_unused_vaddr = ^walk_vaddr[11:0];

  assign walk_done  = r_walk_done;
  assign walk_fault = r_walk_fault;
  assign walk_abort = r_walk_abort;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign entry      = r_entry;
  assign vpn_out    = r_vpn_out;
  assign psize_out  = r_psize;
  assign pte_out    = r_pte_out;
  // The MMU gives invalidate priority over a write in the same cycle, and a
  // reset landing on the write cycle must not leave a stale entry behind.
  assign pte_write  = r_pte_write & ~invalidate & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lvl        <= LVL2;
      r_vpn        <= '0;
      r_pte        <= '0;
      r_err        <= 1'b0;
      r_abort      <= 1'b0;
      r_lp_ctr     <= '0;
      r_np_ctr     <= '0;
      r_walk_done  <= 1'b0;
      r_walk_fault <= 1'b0;
      r_walk_abort <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_entry      <= '0;
      r_vpn_out    <= '0;
      r_psize      <= PSIZE_4KB;
      r_pte_out    <= '0;
      r_pte_write  <= 1'b0;
    end else begin
      r_walk_done <= 1'b0;
      r_pte_write <= 1'b0;
      if (invalidate && r_state != S_IDLE && r_state != S_DONE) r_abort <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_walk_fault <= 1'b0;
          r_walk_abort <= 1'b0;
          if (walk_req) begin
            r_vpn      <= walk_vaddr[VLEN-1:12];
            r_lvl      <= LVL2;
            r_abort    <= 1'b0;
            r_mem_addr <= pte_addr(root_ppn, walk_vaddr[VLEN-1:12], LVL2);
            r_mem_req  <= 1'b1;
            r_state    <= S_READ;
          end
        end
        // Request stays up until ack even when aborted; the data is dropped in CHECK.
        S_READ: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_pte     <= pte_t'(mem_rdata);
            r_err     <= mem_err;
            r_state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_abort) begin
            r_walk_done  <= 1'b1;
            r_walk_abort <= 1'b1;
            r_state      <= S_DONE;
          end else if (r_err || pte_invalid(r_pte)) begin
            r_walk_done  <= 1'b1;
            r_walk_fault <= 1'b1;
            r_state      <= S_DONE;
          end else if (pte_pointer(r_pte)) begin
            if (r_lvl != LVL0) begin
              r_lvl      <= w_next_lvl;
              r_mem_addr <= pte_addr(r_pte.ppn, r_vpn, w_next_lvl);
              r_mem_req  <= 1'b1;
              r_state    <= S_READ;
            end else begin
              r_walk_done  <= 1'b1;
              r_walk_fault <= 1'b1;
              r_state      <= S_DONE;
            end
          end else if (pte_misaligned(r_pte.ppn, r_lvl)) begin
            r_walk_done  <= 1'b1;
            r_walk_fault <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_pte_write <= 1'b1;
            r_pte_out   <= r_pte;
            r_vpn_out   <= r_vpn;
            r_psize     <= lvl_psize(r_lvl);
            r_entry     <= (r_lvl != LVL0) ? 5'(r_lp_ctr) : 5'(r_np_ctr);
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_walk_done <= 1'b1;
          r_state     <= S_DONE;
          if (w_abort) begin
            r_walk_abort <= 1'b1;
          end else if (r_lvl != LVL0) begin
            r_lp_ctr <= r_lp_ctr + LPW'(1);
          end else begin
            r_np_ctr <= r_np_ctr + NPW'(1);
          end
        end
        S_DONE: begin
          r_walk_fault <= 1'b0;
          r_walk_abort <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_page_table_walker.sv
`timescale 1ns/1ps
module tb_page_table_walker;
  import mmu::*;

  localparam int LP_N = 8;
  localparam int NP_N = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              walk_req = 1'b0;
  logic [VLEN-1:0]   walk_vaddr = '0;
  logic [PPNW-1:0]   root_ppn = '0;
  logic              invalidate = 1'b0;
  logic              mem_ack = 1'b0;
  logic [31:0]       mem_rdata = '0;
  logic              mem_err = 1'b0;
  logic              walk_done, walk_fault, walk_abort, mem_req, pte_write;
  logic [PLEN-1:0]   mem_addr;
  logic [4:0]        entry;
  logic [VLEN-13:0]  vpn_out;
  psize_t            psize_out;
  logic [31:0]       pte_out;

  always #5 clock = ~clock;

  page_table_walker #(.lp_tlb_log2count(3), .np_tlb_log2ways(1)) dut (
    .clock(clock), .reset(reset), .walk_req(walk_req), .walk_vaddr(walk_vaddr),
    .root_ppn(root_ppn), .walk_done(walk_done), .walk_fault(walk_fault),
    .walk_abort(walk_abort), .invalidate(invalidate), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .entry(entry), .vpn_out(vpn_out), .psize_out(psize_out), .pte_out(pte_out),
    .pte_write(pte_write)
  );

  int n_checks = 0, n_pass = 0, cyc = 0, req_cyc = 0;
  logic [31:0] mem [logic [33:0]];
  bit rand_fill = 0;
  int ack_lat = 0, err_at = -1, rd_num = 0, hold = 0, last_hold = 0;
  logic [33:0] obs_addrs[$], exp_addrs[$];
  int obs_done = 0, obs_nwr = 0, obs_done_cyc = 0;
  bit obs_fault, obs_abort;
  psize_t obs_psize;
  logic [31:0] obs_pte;
  logic [4:0] obs_entry;
  logic [26:0] obs_vpn;
  bit exp_fault, exp_write;
  psize_t exp_psize;
  logic [31:0] exp_pte;
  logic [4:0] exp_entry;
  logic [26:0] exp_vpn;
  int exp_lat;
  int m_lp = 0, m_np = 0;

  // Page-table memory: missing entries read as 0, or as a random PTE biased
  // toward pointers and leaves when rand_fill is set (then remembered).
  function automatic logic [31:0] get_pte(input logic [33:0] a);
    logic [21:0] ppn;
    logic [31:0] p;
    int k;
    if (mem.exists(a)) return mem[a];
    if (!rand_fill) return 32'h0;
    k = $urandom_range(0, 9);
    ppn = 22'($urandom);
    if ($urandom_range(0, 1) == 1) ppn[17:0] = '0;
    else if ($urandom_range(0, 1) == 1) ppn[8:0] = '0;
    p = {ppn, 10'($urandom)};
    if (k < 5) p[3:0] = 4'b0001;
    else if (k < 8) begin
      p[0] = 1'b1;
      if ($urandom_range(0, 1) == 1) p[1] = 1'b1;
      else begin p[2:1] = 2'b00; p[3] = 1'b1; end
    end
    else if (k == 8) p[0] = 1'b0;
    else p[2:0] = 3'b101;
    mem[a] = p;
    return p;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Memory responder: acks after ack_lat extra cycles, errors on read err_at.
  initial forever begin
    @(posedge clock); #1;
    if (mem_req === 1'b1 && !reset) begin
      hold++;
      if (hold > ack_lat) begin
        mem_ack = 1'b1;
        mem_rdata = get_pte(mem_addr);
        mem_err = (rd_num == err_at);
        obs_addrs.push_back(mem_addr);
        last_hold = hold;
        rd_num++;
        hold = 0;
      end else mem_ack = 1'b0;
    end else begin
      mem_ack = 1'b0;
      mem_err = 1'b0;
      hold = 0;
    end
  end

  initial forever begin
    @(negedge clock);
    if (pte_write === 1'b1) begin
      obs_nwr++; obs_psize = psize_out; obs_pte = pte_out; obs_entry = entry; obs_vpn = vpn_out;
    end
    if (walk_done === 1'b1) begin
      obs_done++; obs_fault = walk_fault; obs_abort = walk_abort; obs_done_cyc = cyc;
    end
  end

  function automatic logic [71:0] pack_out(input int nwr, input bit f, input bit a, input psize_t ps,
                                           input logic [31:0] p, input logic [4:0] e, input logic [26:0] v);
    logic [3:0] n;
    n = 4'(nwr);
    return {n, f, a, ps, p, e, v};
  endfunction

  function automatic logic [105:0] addr_sig(input logic [33:0] q[$]);
    logic [105:0] s;
    s = '0;
    s[105:102] = 4'(q.size());
    for (int i = 0; i < q.size() && i < 3; i++) s[34*i +: 34] = q[i];
    return s;
  endfunction

  // Reference walk straight from the PTE rules, reading the same memory image.
  task automatic model_walk(input logic [38:0] va, input logic [21:0] root, input int lat,
                            input int err, input bit commit);
    logic [21:0] ppn;
    logic [33:0] a;
    logic [31:0] p;
    int reads;
    bit fin;
    ppn = root; reads = 0; fin = 0; exp_addrs.delete();
    exp_fault = 0; exp_write = 0; exp_psize = PSIZE_4KB; exp_pte = '0; exp_entry = '0; exp_vpn = '0;
    for (int lvl = 2; lvl >= 0 && !fin; lvl--) begin
      a = 34'(ppn) * 34'd4096 + 34'((va >> (12 + 9 * lvl)) & 39'h1FF) * 34'd4;
      exp_addrs.push_back(a);
      reads++;
      p = get_pte(a);
      fin = 1;
      if (reads - 1 == err) exp_fault = 1;
      else if (!p[0] || (p[2] && !p[1])) exp_fault = 1;
      else if (!p[1] && !p[3]) begin
        if (lvl == 0) exp_fault = 1;
        else begin ppn = p[31:10]; fin = 0; end
      end
      else if ((lvl == 2 && p[27:10] != 0) || (lvl == 1 && p[18:10] != 0)) exp_fault = 1;
      else begin
        exp_write = 1; exp_pte = p; exp_vpn = va[38:12];
        exp_psize = (lvl == 2) ? PSIZE_1GB : (lvl == 1) ? PSIZE_2MB : PSIZE_4KB;
        if (lvl > 0) begin exp_entry = 5'(m_lp); if (commit) m_lp = (m_lp + 1) % LP_N; end
        else begin exp_entry = 5'(m_np); if (commit) m_np = (m_np + 1) % NP_N; end
      end
    end
    exp_lat = reads * (lat + 2) + (exp_write ? 2 : 1);
  endtask

  task automatic clear_obs();
    obs_addrs.delete(); rd_num = 0;
    obs_done = 0; obs_nwr = 0; obs_fault = 0; obs_abort = 0;
    obs_psize = PSIZE_4KB; obs_pte = '0; obs_entry = '0; obs_vpn = '0;
  endtask

  task automatic issue(input logic [38:0] va, input logic [21:0] root);
    clear_obs();
    @(posedge clock); #1;
    walk_req = 1'b1; walk_vaddr = va; root_ppn = root; req_cyc = cyc;
    @(posedge clock); #1;
    walk_req = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 300 && obs_done == 0; i++) @(posedge clock);
    #1;
    if (obs_done == 0) begin
      n_checks++;
      $display("FAIL %s timeout: walk_done never seen", nm);
    end
  endtask

  task automatic run_walk(input logic [38:0] va, input logic [21:0] root, input int lat, input int err, input string nm);
    ack_lat = lat; err_at = err;
    issue(va, root);
    wait_done(nm);
  endtask

  task automatic set_tables();
    mem.delete(); rand_fill = 0;
    mem[34'h1000] = 32'h0000_0801;
    mem[34'h2000] = 32'h0000_0C01;
    mem[34'h3014] = 32'h0004_00CF;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({walk_done, walk_fault, walk_abort, mem_req, mem_addr, entry, vpn_out, psize_out, pte_out, pte_write} !== 105'b0)
      $display("FAIL reset_outputs got %h want 0", {mem_req, mem_addr, entry, vpn_out, psize_out, pte_out});
    else n_pass++;
    @(posedge clock); #1; reset = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({walk_done, mem_req, pte_write} !== 3'b0) $display("FAIL idle_after_reset got %b want 000", {walk_done, mem_req, pte_write});
    else n_pass++;
  endtask

  task automatic test_4kb();
    logic [71:0] o, e;
    set_tables();
    run_walk(39'h5000, 22'h1, 0, -1, "4kb");
    model_walk(39'h5000, 22'h1, 0, -1, 1);
    o = pack_out(obs_nwr, obs_fault, obs_abort, obs_psize, obs_pte, obs_entry, obs_vpn);
    e = pack_out(exp_write ? 1 : 0, exp_fault, 0, exp_psize, exp_pte, exp_entry, exp_vpn);
    n_checks++; if (o !== e) $display("FAIL 4kb outcome got %h want %h", o, e); else n_pass++;
    n_checks++; if (addr_sig(obs_addrs) !== addr_sig(exp_addrs)) $display("FAIL 4kb addrs got %h want %h", addr_sig(obs_addrs), addr_sig(exp_addrs)); else n_pass++;
    n_checks++; if (obs_done_cyc - req_cyc !== 8) $display("FAIL 4kb latency got %0d want 8", obs_done_cyc - req_cyc); else n_pass++;
    n_checks++; if (obs_pte !== 32'h0004_00CF || obs_vpn !== 27'h5) $display("FAIL 4kb leaf got %h/%h want 000400cf/5", obs_pte, obs_vpn); else n_pass++;
  endtask

  task automatic test_1gb_victim();
    logic [71:0] o, e;
    set_tables();
    mem[34'h1000] = 32'h1000_00CF;
    for (int i = 0; i < 9; i++) begin
      run_walk(39'h5000, 22'h1, 0, -1, "1gb");
      model_walk(39'h5000, 22'h1, 0, -1, 1);
      o = pack_out(obs_nwr, obs_fault, obs_abort, obs_psize, obs_pte, obs_entry, obs_vpn);
      e = pack_out(exp_write ? 1 : 0, exp_fault, 0, exp_psize, exp_pte, exp_entry, exp_vpn);
      n_checks++; if (o !== e) $display("FAIL 1gb[%0d] outcome got %h want %h", i, o, e); else n_pass++;
      n_checks++; if (obs_done_cyc - req_cyc !== exp_lat) $display("FAIL 1gb[%0d] latency got %0d want %0d", i, obs_done_cyc - req_cyc, exp_lat); else n_pass++;
      n_checks++; if (obs_entry !== 5'(i % 8)) $display("FAIL 1gb[%0d] entry got %0d want %0d", i, obs_entry, i % 8); else n_pass++;
    end
  endtask

  task automatic test_faults();
    logic [71:0] o, e;
    int err;
    for (int c = 0; c < 3; c++) begin
      set_tables();
      err = -1;
      if (c == 0) mem[34'h2000] = 32'h0004_04CF;
      else if (c == 1) mem[34'h1000] = 32'h0;
      else err = 1;
      run_walk(39'h5000, 22'h1, 0, err, "fault");
      model_walk(39'h5000, 22'h1, 0, err, 1);
      o = pack_out(obs_nwr, obs_fault, obs_abort, obs_psize, obs_pte, obs_entry, obs_vpn);
      e = pack_out(exp_write ? 1 : 0, exp_fault, 0, exp_psize, exp_pte, exp_entry, exp_vpn);
      n_checks++; if (o !== e) $display("FAIL fault[%0d] outcome got %h want %h", c, o, e); else n_pass++;
      n_checks++; if (addr_sig(obs_addrs) !== addr_sig(exp_addrs)) $display("FAIL fault[%0d] addrs got %h want %h", c, addr_sig(obs_addrs), addr_sig(exp_addrs)); else n_pass++;
      n_checks++; if (obs_done_cyc - req_cyc !== exp_lat) $display("FAIL fault[%0d] latency got %0d want %0d", c, obs_done_cyc - req_cyc, exp_lat); else n_pass++;
    end
  endtask

  task automatic test_reset_write();
    logic [71:0] o, e;
    set_tables();
    ack_lat = 0; err_at = -1;
    issue(39'h5000, 22'h1);
    repeat (6) @(posedge clock);
    #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({4'(obs_nwr), 4'(obs_done), mem_req} !== 9'b0) $display("FAIL reset_write got nwr=%0d done=%0d req=%b want 0/0/0", obs_nwr, obs_done, mem_req);
    else n_pass++;
    m_lp = 0; m_np = 0;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) mem[34'h1000] = 32'h1000_00CF;
      run_walk(39'h5000, 22'h1, 0, -1, "post_reset");
      model_walk(39'h5000, 22'h1, 0, -1, 1);
      o = pack_out(obs_nwr, obs_fault, obs_abort, obs_psize, obs_pte, obs_entry, obs_vpn);
      e = pack_out(exp_write ? 1 : 0, exp_fault, 0, exp_psize, exp_pte, exp_entry, exp_vpn);
      n_checks++; if (o !== e) $display("FAIL post_reset[%0d] outcome got %h want %h", k, o, e); else n_pass++;
    end
  endtask

  task automatic test_invalidate_write();
    logic [71:0] o, e;
    set_tables();
    ack_lat = 0; err_at = -1;
    issue(39'h5000, 22'h1);
    repeat (6) @(posedge clock);
    #1; invalidate = 1'b1;
    @(posedge clock); #1; invalidate = 1'b0;
    wait_done("inv_write");
    model_walk(39'h5000, 22'h1, 0, -1, 0);
    o = pack_out(obs_nwr, obs_fault, obs_abort, obs_psize, obs_pte, obs_entry, obs_vpn);
    e = pack_out(0, 0, 1, PSIZE_4KB, '0, '0, '0);
    n_checks++; if (o !== e) $display("FAIL inv_write outcome got %h want %h", o, e); else n_pass++;
    n_checks++; if (obs_done_cyc - req_cyc !== 8) $display("FAIL inv_write latency got %0d want 8", obs_done_cyc - req_cyc); else n_pass++;
    run_walk(39'h5000, 22'h1, 0, -1, "after_inv");
    model_walk(39'h5000, 22'h1, 0, -1, 1);
    o = pack_out(obs_nwr, obs_fault, obs_abort, obs_psize, obs_pte, obs_entry, obs_vpn);
    e = pack_out(exp_write ? 1 : 0, exp_fault, 0, exp_psize, exp_pte, exp_entry, exp_vpn);
    n_checks++; if (o !== e) $display("FAIL after_inv outcome got %h want %h", o, e); else n_pass++;
  endtask

  task automatic test_abort();
    logic [71:0] o, e;
    logic [33:0] q[$];
    int i;
    set_tables();
    ack_lat = 5; err_at = -1;
    issue(39'h5000, 22'h1);
    for (i = 0; i < 60 && !(rd_num == 1 && hold >= 2); i++) @(posedge clock);
    n_checks++; if (!(rd_num == 1 && hold >= 2)) $display("FAIL abort_setup got rd_num=%0d want 1", rd_num); else n_pass++;
    #2; invalidate = 1'b1;
    @(posedge clock); #2; invalidate = 1'b0;
    wait_done("abort");
    o = pack_out(obs_nwr, obs_fault, obs_abort, obs_psize, obs_pte, obs_entry, obs_vpn);
    e = pack_out(0, 0, 1, PSIZE_4KB, '0, '0, '0);
    n_checks++; if (o !== e) $display("FAIL abort outcome got %h want %h", o, e); else n_pass++;
    q.push_back(34'h1000); q.push_back(34'h2000);
    n_checks++; if (addr_sig(obs_addrs) !== addr_sig(q)) $display("FAIL abort addrs got %h want %h", addr_sig(obs_addrs), addr_sig(q)); else n_pass++;
    n_checks++; if (last_hold !== 6) $display("FAIL abort req_hold got %0d want 6", last_hold); else n_pass++;
    ack_lat = 0;
  endtask

  task automatic test_random();
    logic [71:0] o, e;
    logic [38:0] va;
    logic [21:0] root;
    int lat, err;
    mem.delete(); rand_fill = 1;
    for (int n = 0; n < 40; n++) begin
      va = 39'({$urandom, $urandom});
      root = 22'($urandom);
      lat = $urandom_range(0, 3);
      err = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : -1;
      run_walk(va, root, lat, err, "rand");
      model_walk(va, root, lat, err, 1);
      o = pack_out(obs_nwr, obs_fault, obs_abort, obs_psize, obs_pte, obs_entry, obs_vpn);
      e = pack_out(exp_write ? 1 : 0, exp_fault, 0, exp_psize, exp_pte, exp_entry, exp_vpn);
      n_checks++; if (o !== e) $display("FAIL rand[%0d] outcome got %h want %h", n, o, e); else n_pass++;
      n_checks++; if (addr_sig(obs_addrs) !== addr_sig(exp_addrs)) $display("FAIL rand[%0d] addrs got %h want %h", n, addr_sig(obs_addrs), addr_sig(exp_addrs)); else n_pass++;
      n_checks++; if (obs_done_cyc - req_cyc !== exp_lat) $display("FAIL rand[%0d] latency got %0d want %0d", n, obs_done_cyc - req_cyc, exp_lat); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_4kb();
    test_1gb_victim();
    test_faults();
    test_reset_write();
    test_invalidate_write();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
